// File: rtl/pulse_width_checker_if.sv
// pulse_width_checker_if
//   Bundles the pulse line, counter clear and all measurement results of
//   pulse_width_checker. CW must match the checker's CW parameter.
//   master : side that drives pulse_in/clear and consumes the results
//   slave  : the checker itself
//   Signals:
//     pulse_in   monitored pulse line
//     clear      synchronous clear of good_count/err_count
//     done       one-cycle strobe, pulse completed within MAX_WIDTH
//     width      width of last completed pulse (held)
//     short_err  valid with done: width < MIN_WIDTH
//     stuck      level: current pulse exceeded MAX_WIDTH and is still high
//     good_count saturating count of good pulses
//     err_count  saturating count of short pulses plus stuck events
interface pulse_width_checker_if #(
    parameter int unsigned CW = 8
);
    logic          pulse_in;
    logic          clear;
    logic          done;
    logic [CW-1:0] width;
    logic          short_err;
    logic          stuck;
    logic [15:0]   good_count;
    logic [15:0]   err_count;

    modport master (
        output pulse_in, clear,
        input  done, width, short_err, stuck, good_count, err_count
    );

    modport slave (
        input  pulse_in, clear,
        output done, width, short_err, stuck, good_count, err_count
    );
endinterface

// File: rtl/pulse_width_checker.sv
// pulse_width_checker
//   Receive-side monitor for a single-bit pulse stream. Synchronizes the
//   pulse line, measures each high time in clk cycles and classifies the
//   pulse as good, short or stuck-high.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  pulse_width_checker_if.slave (pulse_in, clear in; done, width,
//          short_err, stuck, good_count, err_count out)
//   Parameters:
//     SYNC_STAGES  input synchronizer depth (0..3, 0 = pulse_in used directly)
//     CW           measurement counter / width output width
//     MIN_WIDTH    shortest legal pulse (>= 1)
//     MAX_WIDTH    longest legal pulse (MIN_WIDTH..2^CW-2)
module pulse_width_checker #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CW          = 8,
    parameter int unsigned MIN_WIDTH   = 5,
    parameter int unsigned MAX_WIDTH   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_width_checker_if.slave bus
);

    localparam logic [CW-1:0] MIN_W = CW'(MIN_WIDTH);
    localparam logic [CW-1:0] MAX_W = CW'(MAX_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        STUCK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          p;
    logic          p_prev;
    logic          rise;

    logic          done_q;
    logic [CW-1:0] width_q;
    logic          short_q;
    logic          stuck_q;
    logic [15:0]   good_q;
    logic [15:0]   err_q;
    logic          good_inc;
    logic          err_inc;

    // Synchronizer flops reset to 1 so a line already high at reset release
    // never produces a rise until it has been seen low.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign p = bus.pulse_in;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= 1'b1;
                else     sync_q <= bus.pulse_in;
            end
            assign p = sync_q;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '1;
                else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
            end
            assign p = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_prev <= 1'b1;
        else     p_prev <= p;
    end

    assign rise = p & ~p_prev;

    // Counter events, decoded from the same state/cnt the FSM acts on so the
    // counts move on the same edge as done or stuck entry.
    always_comb begin
        good_inc = 1'b0;
        err_inc  = 1'b0;
        if (state == HIGH) begin
            if (!p) begin
                good_inc = (cnt >= MIN_W);
                err_inc  = (cnt <  MIN_W);
            end else if (cnt == MAX_W) begin
                err_inc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            done_q  <= 1'b0;
            width_q <= '0;
            short_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CW'(1);
                    end
                end
                HIGH: begin
                    if (!p) begin
                        state   <= IDLE;
                        width_q <= cnt;
                        done_q  <= 1'b1;
                        short_q <= (cnt < MIN_W);
                    end else if (cnt == MAX_W) begin
                        state   <= STUCK;
                        stuck_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STUCK: begin
                    if (!p) begin
                        state   <= IDLE;
                        stuck_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_q <= '0;
            err_q  <= '0;
        end else if (bus.clear) begin
            good_q <= '0;
            err_q  <= '0;
        end else begin
            if (good_inc && good_q != '1) good_q <= good_q + 16'd1;
            else                          good_q <= good_q;
            if (err_inc && err_q != '1)   err_q  <= err_q + 16'd1;
            else                          err_q  <= err_q;
        end
    end

    assign bus.done       = done_q;
    assign bus.width      = width_q;
    assign bus.short_err  = short_q;
    assign bus.stuck      = stuck_q;
    assign bus.good_count = good_q;
    assign bus.err_count  = err_q;

endmodule
